branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-side counterpart of branch_eval. It predicts conditional-branch direction for fetched PCs from a table of 2-bit saturating counters. It holds outstanding predictions in an in-order queue and retires each one against branch_eval's resolved outcome (branch/exception), training the table as it does so. It signals mispredicts and exceptions to the fetch/PC logic and flushes wrong-path predictions.

Parameters:
WIDTH, 32, PC width in bits
ENTRIES, 64, counter table entries; power of 2, >=2; IDXW = clog2(ENTRIES)
DEPTH, 4, max outstanding predictions; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_valid  in  1  fetch requests a prediction for pred_pc
pred_pc  in  WIDTH  PC of fetched branch; index = pred_pc[IDXW+1:2]
pred_ready  out  1  queue can accept a prediction (= occupancy != DEPTH)
pred_taken  out  1  predicted direction, combinational, valid in the cycle pred_valid&&pred_ready
res_valid  in  1  branch_eval result for the oldest outstanding branch
res_branch  in  1  branch_eval.branch (actual taken)
res_exception  in  1  branch_eval.exception (reserved func)
mispredict  out  1  registered; pulses 1 cycle after a mispredicting resolution
mispredict_taken  out  1  registered; actual direction accompanying mispredict
exception_out  out  1  registered; pulses 1 cycle after a res_exception resolution
err_underflow  out  1  registered; pulses 1 cycle after res_valid while queue empty
occupancy  out  clog2(DEPTH+1)  registered count of outstanding predictions

Behaviour:
- Reset (rst=1 at posedge):
  - All counters -> WNT (2'b01).
  - Queue empty (head=tail=0, occupancy=0).
  - mispredict, mispredict_taken, exception_out, err_underflow = 0.
  - pred_ready = 1 after reset.
  - Reset mid-operation discards all outstanding entries with no flag.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11; pred_taken = counter[1].
- Push: on posedge with pred_valid&&pred_ready, enqueue {index, pred_taken} at tail.
  - pred_valid with pred_ready=0 is ignored: no state change, pred_taken don't-care.
- Resolve: on posedge with res_valid and occupancy>0, pop head {idx, p}.
  - If res_exception: no counter update; exception_out=1 next cycle; flush the whole queue (occupancy -> 0, the popped entry included).
  - Otherwise: counter[idx] saturates toward res_branch (+1 capped at ST if 1, -1 floored at SNT if 0).
    - If res_branch != p: mispredict=1 and mispredict_taken=res_branch next cycle; flush all remaining entries.
    - If res_branch == p: normal pop only.
- Underflow: res_valid with occupancy==0 -> err_underflow=1 next cycle; no table or queue change.
- Simultaneous push and resolve:
  - No flush: both take effect; occupancy unchanged.
  - Flush (mispredict or exception): flush wins and the same-cycle push is discarded as wrong-path.
  - When full, pred_ready=0 even if a pop occurs that cycle (ready does not depend on res_valid).
- Same-index read/update in one cycle: pred_taken reflects the pre-update counter; the update lands at the edge.
- Pointers are IDXQ = clog2(DEPTH) bits and wrap modulo DEPTH; full/empty come from occupancy, not pointer compare.
- Flags are single-cycle pulses, cleared the cycle after unless re-triggered.
- PC bits [1:0] and bits above IDXW+1 are ignored, so aliasing PCs share a counter.

Decomposition:
- Shared package (datatypes.sv):
  - bp_ctr_t enum {SNT, WNT, WT, ST}
  - BP_CTR_RESET = WNT
  - bp_entry_t struct {idx, taken}
- Sub-module branch_pred_fifo: parameterised circular queue with push, pop, flush, occupancy.
- branch_predictor contains the table, index/update logic and output flags.

Test Plan:
- Reset, push pc=0x100 -> pred_taken=0, occupancy=1 next cycle; resolve res_branch=0 -> no mispredict, occupancy=0, counter[0] becomes SNT.
- Push pc=0x100, resolve res_branch=1 -> mispredict=1 and mispredict_taken=1 one cycle later. Repeat twice, then push pc=0x200 (aliases idx 0) -> pred_taken=1.
- Push 4 PCs 0x0,0x4,0x8,0xC -> occupancy=4, pred_ready=0; a 5th pred_valid is ignored. Resolve plus push in the same cycle -> push rejected, occupancy=3.
- 3 outstanding, head mispredicts while pred_valid=1 -> occupancy=0 next cycle and the same-cycle push is dropped.
- 2 outstanding, res_valid=1 with res_exception=1 (BRANCH_RESERVED_1 in branch_eval) -> exception_out=1, occupancy=0, indexed counter unchanged, mispredict=0.
- Empty queue, res_valid=1 -> err_underflow=1 for exactly 1 cycle, counters unchanged. Then assert rst with 2 outstanding -> occupancy=0 and all flags 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
//   bp_ctr_t      : 2-bit saturating direction counter encoding
//   BP_CTR_RESET  : value every counter takes at reset (weakly not-taken)
//   bp_ctr_next() : saturating train step toward the resolved direction
//   bp_predict()  : direction implied by a counter (its MSB)
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;

  // Step one state toward the actual direction, saturating at SNT / ST.
  function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
    bp_ctr_t n;
    n = c;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = BP_CTR_RESET;
    endcase
    return n;
  endfunction

  function automatic logic bp_predict(bp_ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between fetch/branch_eval and the branch predictor.
//   master : fetch + branch_eval side (drives requests and resolutions)
//   slave  : predictor side (returns prediction, ready, flags, occupancy)
//
// Handshake: a prediction transfers on a rising clk edge where
// pred_valid && pred_ready; pred_taken is valid in that same cycle.
// pred_ready never depends on res_valid. A resolution has no ready: every
// res_valid cycle is consumed, either popping the oldest entry or, when
// nothing is outstanding, raising err_underflow.
interface branch_predictor_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int OCCW = $clog2(DEPTH + 1);

  logic             pred_valid;
  logic [WIDTH-1:0] pred_pc;
  logic             pred_ready;
  logic             pred_taken;
  logic             res_valid;
  logic             res_branch;
  logic             res_exception;
  logic             mispredict;
  logic             mispredict_taken;
  logic             exception_out;
  logic             err_underflow;
  logic [OCCW-1:0]  occupancy;

  modport master (
    output pred_valid, pred_pc, res_valid, res_branch, res_exception,
    input  pred_ready, pred_taken, mispredict, mispredict_taken,
           exception_out, err_underflow, occupancy
  );

  modport slave (
    input  pred_valid, pred_pc, res_valid, res_branch, res_exception,
    output pred_ready, pred_taken, mispredict, mispredict_taken,
           exception_out, err_underflow, occupancy
  );

endinterface

// File: rtl/branch_pred_fifo.sv
// In-order circular queue of outstanding predictions.
//   clk, rst      : clock, synchronous active-high reset (empties queue)
//   push_i/din_i  : enqueue din_i at tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the queue; overrides a same-cycle push and pop
//   head_o        : oldest entry (meaningless when empty)
//   occupancy_o   : registered entry count; full_o / empty_o derive from it
module branch_pred_fifo #(
  parameter int DW    = 7,
  parameter int DEPTH = 4,
  localparam int IDXQ = $clog2(DEPTH),
  localparam int OCCW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [DW-1:0]   din_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [DW-1:0]   head_o,
  output logic [OCCW-1:0] occupancy_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [IDXQ-1:0] head_q, head_d;
  logic [IDXQ-1:0] tail_q, tail_d;
  logic [OCCW-1:0] occ_q, occ_d;
  logic            push_ok;
  logic            pop_ok;

  // Full/empty come from the count, so the pointers may simply wrap.
  assign full_o      = (occ_q == OCCW'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign head_o      = mem_q[head_q];
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_ok) tail_d = tail_q + IDXQ'(1);
      if (pop_ok)  head_d = head_q + IDXQ'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + OCCW'(1);
        2'b01:   occ_d = occ_q - OCCW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Payload storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[tail_q] <= din_i;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side conditional-branch predictor.
// A table of 2-bit saturating counters, indexed by pred_pc[IDXW+1:2],
// predicts direction. Each accepted prediction is queued in order and is
// retired against branch_eval's resolution, which trains the counter and
// raises mispredict / exception_out; those flush all wrong-path entries.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_predictor_if slave modport (see the interface header)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bus
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int OCCW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            taken;
  } bp_entry_t;

  bp_ctr_t         table_q [ENTRIES];
  logic [IDXW-1:0] pred_idx;
  logic            unused_pc_bits;
  logic            push;
  bp_entry_t       push_entry;
  bp_entry_t       head_entry;
  logic [OCCW-1:0] occ;
  logic            full;
  logic            empty;
  logic            res_fire;
  logic            train;
  logic            flush;

  logic mispredict_q, mispredict_d;
  logic mis_taken_q, mis_taken_d;
  logic exception_q, exception_d;
  logic underflow_q, underflow_d;

  // Word-aligned PC bits pick the counter; higher bits alias on purpose.
  assign pred_idx       = bus.pred_pc[IDXW+1:2];
  assign unused_pc_bits = ^{bus.pred_pc[WIDTH-1:IDXW+2], bus.pred_pc[1:0]};

  // Read is from the registered table, so a same-cycle update to the same
  // index is not visible until the following cycle.
  assign bus.pred_taken = bp_predict(table_q[pred_idx]);
  assign bus.pred_ready = !full;

  assign push             = bus.pred_valid && !full;
  assign push_entry.idx   = pred_idx;
  assign push_entry.taken = bus.pred_taken;

  assign res_fire = bus.res_valid && !empty;
  assign train    = res_fire && !bus.res_exception;

  always_comb begin
    mispredict_d = 1'b0;
    mis_taken_d  = 1'b0;
    exception_d  = 1'b0;
    underflow_d  = 1'b0;
    if (res_fire) begin
      if (bus.res_exception) begin
        exception_d = 1'b1;
      end else if (bus.res_branch != head_entry.taken) begin
        mispredict_d = 1'b1;
        mis_taken_d  = bus.res_branch;
      end
    end else if (bus.res_valid) begin
      underflow_d = 1'b1;
    end
  end

  // Both flush causes also drop the entry being popped and any same-cycle
  // push, since everything younger than the resolving branch is wrong-path.
  assign flush = mispredict_d || exception_d;

  branch_pred_fifo #(
    .DW    ($bits(bp_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .din_i       (push_entry),
    .pop_i       (res_fire),
    .flush_i     (flush),
    .head_o      (head_entry),
    .occupancy_o (occ),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BP_CTR_RESET;
    end else if (train) begin
      table_q[head_entry.idx] <= bp_ctr_next(table_q[head_entry.idx], bus.res_branch);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      mis_taken_q  <= 1'b0;
      exception_q  <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      mispredict_q <= mispredict_d;
      mis_taken_q  <= mis_taken_d;
      exception_q  <= exception_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.mispredict_taken = mis_taken_q;
  assign bus.exception_out    = exception_q;
  assign bus.err_underflow    = underflow_q;
  assign bus.occupancy        = occ;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (WIDTH=32, ENTRIES=64, DEPTH=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// looked at 1 unit later and registered outputs right after the edge.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  branch_predictor_if #(.WIDTH(32), .DEPTH(4)) bus ();

  branch_predictor #(.WIDTH(32), .ENTRIES(64), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.pred_valid    = 1'b0;
    bus.res_valid     = 1'b0;
    bus.res_branch    = 1'b0;
    bus.res_exception = 1'b0;
  endtask

  task automatic drive_push(input logic [31:0] pc);
    bus.pred_valid = 1'b1;
    bus.pred_pc    = pc;
  endtask

  task automatic drive_resolve(input logic br, input logic exc);
    bus.res_valid     = 1'b1;
    bus.res_branch    = br;
    bus.res_exception = exc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.pred_pc = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd0) begin
      errors++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy);
    end
    checks++;
    if (bus.pred_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.pred_ready);
    end
    checks++;
    if ({bus.mispredict, bus.mispredict_taken, bus.exception_out, bus.err_underflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
        {bus.mispredict, bus.mispredict_taken, bus.exception_out, bus.err_underflow});
    end
  endtask

  // pc 0x100 -> idx 0 (WNT, predicts 0); resolve not-taken -> SNT.
  task automatic test_basic;
    drive_push(32'h100);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL basic_pred: got %b want 0", bus.pred_taken);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd1) begin
      errors++; $display("FAIL basic_occ_push: got %0d want 1", bus.occupancy);
    end
    drive_resolve(1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL basic_mp: got %b want 0", bus.mispredict);
    end
    checks++;
    if (bus.occupancy !== 3'd0) begin
      errors++; $display("FAIL basic_occ_pop: got %0d want 0", bus.occupancy);
    end
  endtask

  // idx 0 trajectory: SNT -1-> WNT -1-> WT -1-> ST -0-> WT
  task automatic test_train;
    logic [31:0] pcs [4];
    logic        exp_pred [4];
    logic        res [4];
    logic        exp_mp [4];
    logic        exp_mt [4];
    pcs      = '{32'h100, 32'h100, 32'h200, 32'h100};
    exp_pred = '{1'b0, 1'b0, 1'b1, 1'b1};
    res      = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_mp   = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_mt   = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_push(pcs[i]);
      #1;
      checks++;
      if (bus.pred_taken !== exp_pred[i]) begin
        errors++; $display("FAIL train_pred[%0d]: got %b want %b", i, bus.pred_taken, exp_pred[i]);
      end
      tick();
      idle_inputs();
      drive_resolve(res[i], 1'b0);
      tick();
      idle_inputs();
      checks++;
      if ({bus.mispredict, bus.mispredict_taken} !== {exp_mp[i], exp_mt[i]}) begin
        errors++; $display("FAIL train_mp[%0d]: got %b%b want %b%b", i,
          bus.mispredict, bus.mispredict_taken, exp_mp[i], exp_mt[i]);
      end
      tick();
      checks++;
      if (bus.mispredict !== 1'b0) begin
        errors++; $display("FAIL train_mp_pulse[%0d]: got %b want 0", i, bus.mispredict);
      end
    end
  endtask

  // idx0=WT, idx1..3=WNT. Fill, reject 5th, pop+push while full.
  task automatic test_full;
    logic [31:0] pcs [4];
    logic        exp_pred [4];
    pcs      = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_pred = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_push(pcs[i]);
      #1;
      checks++;
      if (bus.pred_taken !== exp_pred[i]) begin
        errors++; $display("FAIL full_pred[%0d]: got %b want %b", i, bus.pred_taken, exp_pred[i]);
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd4) begin
      errors++; $display("FAIL full_occ: got %0d want 4", bus.occupancy);
    end
    checks++;
    if (bus.pred_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", bus.pred_ready);
    end
    drive_push(32'h10);
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd4) begin
      errors++; $display("FAIL full_ignore: got %0d want 4", bus.occupancy);
    end
    drive_resolve(1'b1, 1'b0);
    drive_push(32'h10);
    #1;
    checks++;
    if (bus.pred_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_pop: got %b want 0", bus.pred_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd3) begin
      errors++; $display("FAIL full_pop_push: got %0d want 3", bus.occupancy);
    end
    checks++;
    if (bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL full_mp: got %b want 0", bus.mispredict);
    end
  endtask

  // 3 outstanding (idx1,2,3 predicted 0); head resolves taken with a push.
  task automatic test_flush;
    drive_resolve(1'b1, 1'b0);
    drive_push(32'h14);
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd0) begin
      errors++; $display("FAIL flush_occ: got %0d want 0", bus.occupancy);
    end
    checks++;
    if ({bus.mispredict, bus.mispredict_taken} !== 2'b11) begin
      errors++; $display("FAIL flush_mp: got %b%b want 11", bus.mispredict, bus.mispredict_taken);
    end
    tick();
    checks++;
    if (bus.occupancy !== 3'd0) begin
      errors++; $display("FAIL flush_occ_hold: got %0d want 0", bus.occupancy);
    end
  endtask

  // idx1=WT, idx2=WNT. Pop+push without flush, then a same-index read
  // during a training update.
  task automatic test_back_to_back;
    drive_push(32'h4);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      errors++; $display("FAIL b2b_pred0: got %b want 1", bus.pred_taken);
    end
    tick();
    idle_inputs();
    drive_resolve(1'b1, 1'b0);
    drive_push(32'h8);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL b2b_pred1: got %b want 0", bus.pred_taken);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd1) begin
      errors++; $display("FAIL b2b_occ: got %0d want 1", bus.occupancy);
    end
    checks++;
    if (bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL b2b_mp: got %b want 0", bus.mispredict);
    end
    drive_resolve(1'b1, 1'b0);
    drive_push(32'h8);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL b2b_same_idx: got %b want 0", bus.pred_taken);
    end
    tick();
    idle_inputs();
    checks++;
    if ({bus.mispredict, bus.mispredict_taken, bus.occupancy} !== {2'b11, 3'd0}) begin
      errors++; $display("FAIL b2b_flush: got mp=%b mt=%b occ=%0d want mp=1 mt=1 occ=0",
        bus.mispredict, bus.mispredict_taken, bus.occupancy);
    end
    tick();
  endtask

  // idx3=WNT, idx1=ST. Exception must not train idx3.
  task automatic test_exception;
    drive_push(32'hC);
    tick();
    drive_push(32'h4);
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd2) begin
      errors++; $display("FAIL exc_occ_pre: got %0d want 2", bus.occupancy);
    end
    drive_resolve(1'b1, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (bus.exception_out !== 1'b1) begin
      errors++; $display("FAIL exc_out: got %b want 1", bus.exception_out);
    end
    checks++;
    if (bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL exc_mp: got %b want 0", bus.mispredict);
    end
    checks++;
    if (bus.occupancy !== 3'd0) begin
      errors++; $display("FAIL exc_occ: got %0d want 0", bus.occupancy);
    end
    tick();
    checks++;
    if (bus.exception_out !== 1'b0) begin
      errors++; $display("FAIL exc_pulse: got %b want 0", bus.exception_out);
    end
    drive_push(32'hC);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL exc_no_train: got %b want 0", bus.pred_taken);
    end
    tick();
    idle_inputs();
    drive_resolve(1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if ({bus.mispredict, bus.occupancy} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL exc_after: got mp=%b occ=%0d want mp=0 occ=0",
        bus.mispredict, bus.occupancy);
    end
  endtask

  // Empty queue resolve; idx0 stays ST afterwards.
  task automatic test_underflow;
    drive_resolve(1'b0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (bus.err_underflow !== 1'b1) begin
      errors++; $display("FAIL uf_flag: got %b want 1", bus.err_underflow);
    end
    checks++;
    if ({bus.mispredict, bus.exception_out, bus.occupancy} !== {2'b00, 3'd0}) begin
      errors++; $display("FAIL uf_side: got mp=%b exc=%b occ=%0d want 0 0 0",
        bus.mispredict, bus.exception_out, bus.occupancy);
    end
    tick();
    checks++;
    if (bus.err_underflow !== 1'b0) begin
      errors++; $display("FAIL uf_pulse: got %b want 0", bus.err_underflow);
    end
    drive_push(32'h0);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      errors++; $display("FAIL uf_table: got %b want 1", bus.pred_taken);
    end
    tick();
    idle_inputs();
    drive_resolve(1'b1, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL uf_resolve: got %b want 0", bus.mispredict);
    end
  endtask

  // Reset with 2 outstanding and a would-be mispredict pending.
  task automatic test_reset_mid;
    drive_push(32'h0);
    tick();
    drive_push(32'h4);
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd2) begin
      errors++; $display("FAIL rmid_occ_pre: got %0d want 2", bus.occupancy);
    end
    rst = 1'b1;
    drive_resolve(1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd0) begin
      errors++; $display("FAIL rmid_occ: got %0d want 0", bus.occupancy);
    end
    checks++;
    if ({bus.mispredict, bus.mispredict_taken, bus.exception_out, bus.err_underflow} !== 4'b0000) begin
      errors++; $display("FAIL rmid_flags: got %b want 0000",
        {bus.mispredict, bus.mispredict_taken, bus.exception_out, bus.err_underflow});
    end
    checks++;
    if (bus.pred_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_ready: got %b want 1", bus.pred_ready);
    end
    drive_push(32'h0);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL rmid_table: got %b want 0", bus.pred_taken);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.occupancy !== 3'd1) begin
      errors++; $display("FAIL rmid_push: got %0d want 1", bus.occupancy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_train();
    test_full();
    test_flush();
    test_back_to_back();
    test_exception();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
